// File: rtl/jedro_1_lsu_hs.sv
// jedro_1_lsu_hs: load-store unit with a request/grant/rvalid memory handshake.
// Handles byte/half/word accesses with byte enables, and sign or zero extension on loads.
// At most one access is outstanding at a time.
// Optional macro LSU_MISALIGN_EXC_EN: when defined, misaligned half/word accesses raise err_o.
// When it is not defined, the low address bits are cleared and the access proceeds.
module jedro_1_lsu_hs #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      ctrl_valid_i,
  output logic                      ctrl_ready_o,
  input  logic                      ctrl_we_i,
  input  logic [1:0]                ctrl_size_i,
  input  logic                      ctrl_unsigned_i,
  input  logic [ADDR_WIDTH-1:0]     addr_i,
  input  logic [DATA_WIDTH-1:0]     wdata_i,
  input  logic [REG_ADDR_WIDTH-1:0] regdest_i,
  output logic [DATA_WIDTH-1:0]     rf_wdata_o,
  output logic                      rf_wb_o,
  output logic [REG_ADDR_WIDTH-1:0] rf_regdest_o,
  output logic                      err_o,
  output logic                      mem_req_o,
  input  logic                      mem_gnt_i,
  output logic [ADDR_WIDTH-1:0]     mem_addr_o,
  output logic                      mem_we_o,
  output logic [DATA_WIDTH/8-1:0]   mem_be_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  input  logic                      mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i
);

  localparam int LANES = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, WB} state_t;

  state_t                    state;
  logic [1:0]                a_lo_q;
  logic [1:0]                size_q;
  logic                      unsigned_q;
  logic [REG_ADDR_WIDTH-1:0] regdest_q;

  logic                  acc_fault;
  logic [LANES-1:0]      st_be;
  logic [DATA_WIDTH-1:0] st_wdata;
  logic [DATA_WIDTH-1:0] ld_data;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;

  // Classify the incoming request as a fault (illegal size, and misalignment when enabled).
  always_comb begin
    acc_fault = (ctrl_size_i == 2'b11);
`ifdef LSU_MISALIGN_EXC_EN
    if ((ctrl_size_i == 2'b01) && addr_i[0])
      acc_fault = 1'b1;
    if ((ctrl_size_i == 2'b10) && (addr_i[1:0] != 2'b00))
      acc_fault = 1'b1;
`endif
  end

  // Build the byte enables and the lane-replicated store data for the incoming request.
  always_comb begin
    st_be    = '1;
    st_wdata = wdata_i;
    if (ctrl_we_i) begin
      case (ctrl_size_i)
        2'b00: begin
          st_be    = {{(LANES-1){1'b0}}, 1'b1} << addr_i[1:0];
          st_wdata = {4{wdata_i[7:0]}};
        end
        2'b01: begin
          st_be    = {{(LANES-2){1'b0}}, 2'b11} << {addr_i[1], 1'b0};
          st_wdata = {2{wdata_i[15:0]}};
        end
        default: begin
          st_be    = '1;
          st_wdata = wdata_i;
        end
      endcase
    end
  end

  // Select the addressed lane of the returned word and extend it to full width.
  always_comb begin
    ld_byte = mem_rdata_i[{a_lo_q, 3'b000} +: 8];
    ld_half = mem_rdata_i[{a_lo_q[1], 4'b0000} +: 16];
    ld_data = mem_rdata_i;
    case (size_q)
      2'b00:   ld_data = unsigned_q ? {{(DATA_WIDTH-8){1'b0}}, ld_byte}
                                    : {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = unsigned_q ? {{(DATA_WIDTH-16){1'b0}}, ld_half}
                                    : {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
      default: ld_data = mem_rdata_i;
    endcase
  end

  // Handshake FSM; every output is registered here.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      ctrl_ready_o <= 1'b1;
      rf_wdata_o   <= '0;
      rf_wb_o      <= 1'b0;
      rf_regdest_o <= '0;
      err_o        <= 1'b0;
      mem_req_o    <= 1'b0;
      mem_addr_o   <= '0;
      mem_we_o     <= 1'b0;
      mem_be_o     <= '0;
      mem_wdata_o  <= '0;
      a_lo_q       <= '0;
      size_q       <= '0;
      unsigned_q   <= 1'b0;
      regdest_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          err_o   <= 1'b0;
          rf_wb_o <= 1'b0;
          if (ctrl_valid_i) begin
            if (acc_fault) begin
              err_o <= 1'b1;
            end else begin
              a_lo_q       <= addr_i[1:0];
              size_q       <= ctrl_size_i;
              unsigned_q   <= ctrl_unsigned_i;
              regdest_q    <= regdest_i;
              mem_addr_o   <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
              mem_we_o     <= ctrl_we_i;
              mem_be_o     <= st_be;
              mem_wdata_o  <= st_wdata;
              mem_req_o    <= 1'b1;
              ctrl_ready_o <= 1'b0;
              state        <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            if (mem_we_o) begin
              ctrl_ready_o <= 1'b1;
              state        <= IDLE;
            end else begin
              state <= WAIT_R;
            end
          end
        end
        WAIT_R: begin
          if (mem_rvalid_i) begin
            rf_wdata_o   <= ld_data;
            rf_regdest_o <= regdest_q;
            rf_wb_o      <= 1'b1;
            state        <= WB;
          end
        end
        WB: begin
          rf_wb_o      <= 1'b0;
          ctrl_ready_o <= 1'b1;
          state        <= IDLE;
        end
        default: begin
          state        <= IDLE;
          ctrl_ready_o <= 1'b1;
          mem_req_o    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jedro_1_lsu_hs.sv
// tb_jedro_1_lsu_hs: directed self-checking bench for jedro_1_lsu_hs.
// Expected values are hand-computed per vector; the LSU_MISALIGN_EXC_EN build is also covered.
module tb_jedro_1_lsu_hs;

  logic        clk;
  logic        rst;
  logic        ctrl_valid;
  logic        ctrl_ready;
  logic        ctrl_we;
  logic [1:0]  ctrl_size;
  logic        ctrl_unsigned;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [4:0]  regdest;
  logic [31:0] rf_wdata;
  logic        rf_wb;
  logic [4:0]  rf_regdest;
  logic        err;
  logic        mem_req;
  logic        mem_gnt;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int compared   = 0;
  int mismatched = 0;

  jedro_1_lsu_hs dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .ctrl_valid_i    (ctrl_valid),
    .ctrl_ready_o    (ctrl_ready),
    .ctrl_we_i       (ctrl_we),
    .ctrl_size_i     (ctrl_size),
    .ctrl_unsigned_i (ctrl_unsigned),
    .addr_i          (addr),
    .wdata_i         (wdata),
    .regdest_i       (regdest),
    .rf_wdata_o      (rf_wdata),
    .rf_wb_o         (rf_wb),
    .rf_regdest_o    (rf_regdest),
    .err_o           (err),
    .mem_req_o       (mem_req),
    .mem_gnt_i       (mem_gnt),
    .mem_addr_o      (mem_addr),
    .mem_we_o        (mem_we),
    .mem_be_o        (mem_be),
    .mem_wdata_o     (mem_wdata),
    .mem_rvalid_i    (mem_rvalid),
    .mem_rdata_i     (mem_rdata)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
    ctrl_valid    = 1'b1;
    ctrl_we       = we;
    ctrl_size     = size;
    ctrl_unsigned = uns;
    addr          = a;
    wdata         = wd;
    regdest       = rd;
    tick();
    ctrl_valid    = 1'b0;
    ctrl_we       = 1'b0;
    ctrl_size     = 2'b00;
    ctrl_unsigned = 1'b0;
    addr          = '0;
    wdata         = '0;
    regdest       = '0;
  endtask

  task automatic doStore(input string tag, input logic [1:0] size, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] expAddr,
                         input logic [3:0] expBe, input logic [31:0] expWdata, input int gntDelay);
    checkOutput({tag, "_ready_before"}, ctrl_ready, 1);
    applyStimulus(1'b1, size, 1'b0, a, wd, 5'd0);
    for (int i = 0; i <= gntDelay; i++) begin
      checkOutput({tag, "_req"}, mem_req, 1);
      checkOutput({tag, "_addr"}, mem_addr, expAddr);
      checkOutput({tag, "_be"}, mem_be, expBe);
      checkOutput({tag, "_wdata"}, mem_wdata, expWdata);
      checkOutput({tag, "_we"}, mem_we, 1);
      checkOutput({tag, "_ready_busy"}, ctrl_ready, 0);
      if (i < gntDelay) tick();
    end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    checkOutput({tag, "_req_after_gnt"}, mem_req, 0);
    checkOutput({tag, "_ready_after_gnt"}, ctrl_ready, 1);
    checkOutput({tag, "_no_wb"}, rf_wb, 0);
  endtask

  task automatic doLoad(input string tag, input logic [1:0] size, input logic uns,
                        input logic [31:0] a, input logic [4:0] rd, input logic [31:0] rdata,
                        input int gntDelay, input int rvDelay,
                        input logic [31:0] expAddr, input logic [31:0] expData);
    checkOutput({tag, "_ready_before"}, ctrl_ready, 1);
    applyStimulus(1'b0, size, uns, a, 32'h0, rd);
    for (int i = 0; i <= gntDelay; i++) begin
      checkOutput({tag, "_req"}, mem_req, 1);
      checkOutput({tag, "_addr"}, mem_addr, expAddr);
      checkOutput({tag, "_be"}, mem_be, 4'b1111);
      checkOutput({tag, "_we"}, mem_we, 0);
      if (i < gntDelay) tick();
    end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    checkOutput({tag, "_req_after_gnt"}, mem_req, 0);
    checkOutput({tag, "_ready_wait"}, ctrl_ready, 0);
    for (int i = 1; i < rvDelay; i++) begin
      mem_gnt = (i == 1);
      tick();
      mem_gnt = 1'b0;
      checkOutput({tag, "_no_early_wb"}, rf_wb, 0);
      checkOutput({tag, "_no_req_wait"}, mem_req, 0);
    end
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h5A5A_5A5A;
    checkOutput({tag, "_wb"}, rf_wb, 1);
    checkOutput({tag, "_data"}, rf_wdata, expData);
    checkOutput({tag, "_rd"}, rf_regdest, rd);
    checkOutput({tag, "_ready_wb"}, ctrl_ready, 0);
    tick();
    checkOutput({tag, "_wb_pulse"}, rf_wb, 0);
    checkOutput({tag, "_ready_after"}, ctrl_ready, 1);
  endtask

  task automatic doErr(input string tag, input logic [1:0] size, input logic [31:0] a);
    applyStimulus(1'b0, size, 1'b0, a, 32'h0, 5'd3);
    checkOutput({tag, "_err"}, err, 1);
    checkOutput({tag, "_no_req"}, mem_req, 0);
    checkOutput({tag, "_ready"}, ctrl_ready, 1);
    tick();
    checkOutput({tag, "_err_pulse"}, err, 0);
    checkOutput({tag, "_still_no_req"}, mem_req, 0);
  endtask

  initial begin
    rst           = 1'b1;
    ctrl_valid    = 1'b0;
    ctrl_we       = 1'b0;
    ctrl_size     = 2'b00;
    ctrl_unsigned = 1'b0;
    addr          = '0;
    wdata         = '0;
    regdest       = '0;
    mem_gnt       = 1'b0;
    mem_rvalid    = 1'b0;
    mem_rdata     = '0;
    tick();
    tick();
    checkOutput("rst_ready", ctrl_ready, 1);
    checkOutput("rst_req", mem_req, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_wb", rf_wb, 0);
    checkOutput("rst_addr", mem_addr, 0);
    checkOutput("rst_be", mem_be, 0);
    checkOutput("rst_we", mem_we, 0);
    checkOutput("rst_rfdata", rf_wdata, 0);
    rst = 1'b0;
    tick();

    // Stray grant and rvalid while idle must be ignored.
    mem_gnt    = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1234_5678;
    tick();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    checkOutput("idle_stray_wb", rf_wb, 0);
    checkOutput("idle_stray_req", mem_req, 0);
    checkOutput("idle_stray_ready", ctrl_ready, 1);

    doStore("st_word", 2'b10, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 2);
    doStore("st_byte", 2'b00, 32'h0000_0011, 32'h0000_00A5, 32'h0000_0010, 4'b0010, 32'hA5A5_A5A5, 0);
    doStore("st_half", 2'b01, 32'h0000_0002, 32'h0000_1234, 32'h0000_0000, 4'b1100, 32'h1234_1234, 1);
    doStore("st_byte3", 2'b00, 32'h0000_0023, 32'hFFFF_FF3C, 32'h0000_0020, 4'b1000, 32'h3C3C_3C3C, 0);

    doLoad("ld_sbyte", 2'b00, 1'b0, 32'h0000_0203, 5'd7, 32'h8011_2233, 0, 3, 32'h0000_0200, 32'hFFFF_FF80);
    doLoad("ld_uhalf", 2'b01, 1'b1, 32'h0000_0202, 5'd9, 32'h8001_ABCD, 1, 1, 32'h0000_0200, 32'h0000_8001);
    doLoad("ld_shalf", 2'b01, 1'b0, 32'h0000_0202, 5'd10, 32'h8001_ABCD, 0, 2, 32'h0000_0200, 32'hFFFF_8001);
    doLoad("ld_shalf0", 2'b01, 1'b0, 32'h0000_0200, 5'd11, 32'h8001_ABCD, 0, 1, 32'h0000_0200, 32'hFFFF_ABCD);
    doLoad("ld_ubyte1", 2'b00, 1'b1, 32'h0000_0201, 5'd12, 32'h8011_22F3, 0, 1, 32'h0000_0200, 32'h0000_0022);
    doLoad("ld_ubyte0", 2'b00, 1'b1, 32'h0000_0200, 5'd13, 32'h8011_22F3, 0, 1, 32'h0000_0200, 32'h0000_00F3);
    doLoad("ld_word", 2'b10, 1'b0, 32'h0000_0300, 5'd31, 32'hCAFE_F00D, 2, 2, 32'h0000_0300, 32'hCAFE_F00D);

`ifdef LSU_MISALIGN_EXC_EN
    doErr("mis_word", 2'b10, 32'h0000_0102);
    doErr("mis_half", 2'b01, 32'h0000_0201);
`else
    doLoad("mis_word", 2'b10, 1'b0, 32'h0000_0102, 5'd4, 32'h1357_9BDF, 0, 1, 32'h0000_0100, 32'h1357_9BDF);
    doLoad("mis_half", 2'b01, 1'b1, 32'h0000_0203, 5'd5, 32'h8001_ABCD, 0, 1, 32'h0000_0200, 32'h0000_8001);
`endif
    doErr("size11", 2'b11, 32'h0000_0100);

    // Reset while waiting for read data, then a late rvalid.
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0, 5'd6);
    checkOutput("rstmid_req", mem_req, 1);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rstmid_req_low", mem_req, 0);
    checkOutput("rstmid_ready", ctrl_ready, 1);
    checkOutput("rstmid_no_wb", rf_wb, 0);
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hFFFF_FFFF;
    tick();
    mem_rvalid = 1'b0;
    checkOutput("late_rvalid_no_wb", rf_wb, 0);
    checkOutput("late_rvalid_ready", ctrl_ready, 1);
    checkOutput("late_rvalid_req", mem_req, 0);
    tick();
    checkOutput("late_rvalid_no_wb2", rf_wb, 0);

    doLoad("ld_after_rst", 2'b00, 1'b0, 32'h0000_0502, 5'd8, 32'h0011_7F00, 0, 1, 32'h0000_0500, 32'h0000_0011);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
